// File: rtl/dff_mem_pkg.sv
// rtl/dff_mem_pkg.sv - shared types and widths for the arbitrated DFF byte RAM (DFF_MEM_ARB_PARITY_EN adds a parity bit)
package dff_mem_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

`ifdef DFF_MEM_ARB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dff_mem_core.sv
// rtl/dff_mem_core.sv - flop-based RAM, synchronous write, combinational read, no reset
module dff_mem_core #(
  parameter int ADDR_W    = 4,
  parameter int WORD_W    = 8,
  parameter int RAM_BYTES = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [RAM_BYTES];

  // Contents are deliberately left unreset so the array stays plain flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dff_mem_arbiter.sv
// rtl/dff_mem_arbiter.sv - round-robin two-port front end for dff_mem_core (DFF_MEM_ARB_PARITY_EN adds rerr/inj_perr)
module dff_mem_arbiter
  import dff_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RAM_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
`ifdef DFF_MEM_ARB_PARITY_EN
  input  logic              inj_perr,
  output logic              rerr,
`endif
  output logic              busy
);

  localparam int WORD_W = DATA_W + PAR_W;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              ptr_b;
  logic              sel_b;
  logic              in_grant;
  logic              acc_we;
  logic              acc_rd;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  assign sel_b     = (state == GRANT_B);
  assign in_grant  = (state != IDLE);
  assign acc_we    = sel_b ? we_b    : we_a;
  assign acc_addr  = sel_b ? addr_b  : addr_a;
  assign acc_wdata = sel_b ? wdata_b : wdata_a;
  assign acc_rd    = in_grant && !acc_we;
  assign mem_we    = in_grant && acc_we && !rst;

`ifdef DFF_MEM_ARB_PARITY_EN
  assign mem_wdata = {(^acc_wdata) ^ inj_perr, acc_wdata};
`else
  assign mem_wdata = acc_wdata;
`endif

  assign gnt_a = (state == GRANT_A);
  assign gnt_b = sel_b;
  assign busy  = in_grant;

  // Arbitrate only from IDLE; every grant falls back to IDLE, forcing a bubble.
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) begin
      if (req_a && (!req_b || !ptr_b)) begin
        state_nxt = GRANT_A;
      end else if (req_b) begin
        state_nxt = GRANT_B;
      end
    end
  end

  // State and round-robin pointer; the pointer always favours the loser of the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr_b <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT_A) begin
        ptr_b <= 1'b1;
      end else if (state_nxt == GRANT_B) begin
        ptr_b <= 1'b0;
      end
    end
  end

  // Read capture at the edge ending the grant; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= acc_rd && !sel_b;
      rvalid_b <= acc_rd && sel_b;
      if (acc_rd) begin
        rdata <= mem_rdata[DATA_W-1:0];
      end
    end
  end

`ifdef DFF_MEM_ARB_PARITY_EN
  // Stored words carry even parity, so any odd word is a parity error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rerr <= 1'b0;
    end else begin
      rerr <= acc_rd && (^mem_rdata);
    end
  end
`endif

  dff_mem_core #(
    .ADDR_W   (ADDR_W),
    .WORD_W   (WORD_W),
    .RAM_BYTES(RAM_BYTES)
  ) u_core (
    .clk  (clk),
    .we   (mem_we),
    .addr (acc_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

`ifndef SYNTHESIS
  logic pend_a;
  logic pend_b;

  // A request seen without its grant must still be present on the next edge.
  always_ff @(posedge clk) begin
    if (!rst && pend_a) begin
      a_hold_req_a: assert (req_a);
    end
    if (!rst && pend_b) begin
      a_hold_req_b: assert (req_b);
    end
    pend_a <= !rst && req_a && !gnt_a;
    pend_b <= !rst && req_b && !gnt_b;
  end
`endif

endmodule
